// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared widths, FSM state encoding and the sine-table generator
// for the BPSK modulator.
//   ADDR_W   : sine table address width (1024 entries)
//   SAMPLE_W : signed output sample width
//   ACC_W    : phase accumulator width
//   sin_entry(k) returns round(127*sin(2*pi*k/1024)). It is evaluated at
//   elaboration only, using 64-bit fixed-point arithmetic, so the table
//   needs no real-number support from the synthesis tool.
package bpsk_pkg;

    localparam int ADDR_W      = 10;
    localparam int SAMPLE_W    = 8;
    localparam int ACC_W       = 32;
    localparam int TABLE_DEPTH = 1 << ADDR_W;
    localparam int SIN_AMP     = 127;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Quarter-wave Taylor series in Q30. x <= pi/2, so eight terms leave the
    // truncation error far below the 1/127 rounding step.
    function automatic logic signed [SAMPLE_W-1:0] sin_entry(input int k);
        longint pi_q;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint mag;
        int     p;
        int     q;
        pi_q = 64'sd3373259426;
        p    = k % 512;
        q    = (p > 256) ? (512 - p) : p;
        x    = (pi_q * q) / 512;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / (2 * n * (2 * n + 1));
            sum  = sum + term;
        end
        mag = (SIN_AMP * sum + (64'sd1 <<< 29)) >>> 30;
        if (mag < 0) begin
            mag = 0;
        end
        if (((k / 512) % 2) == 1) begin
            mag = -mag;
        end
        return SAMPLE_W'(mag);
    endfunction

endpackage

// File: rtl/bpsk_sin_rom.sv
// bpsk_sin_rom: 1024 x 8 signed sine table with registered read.
// Ports:
//   clk     in   system clock
//   reset_n in   asynchronous active-low reset (clears the read register)
//   addr    in   table address (phase accumulator MSBs)
//   data    out  table entry for addr, one clock later
module bpsk_sin_rom
    import bpsk_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          addr,
    output logic signed [SAMPLE_W-1:0] data
);

    logic signed [SAMPLE_W-1:0] table_w [TABLE_DEPTH];

    for (genvar k = 0; k < TABLE_DEPTH; k++) begin : g_table
        localparam logic signed [SAMPLE_W-1:0] ENTRY = sin_entry(k);
        assign table_w[k] = ENTRY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= table_w[addr];
        end
    end

endmodule

// File: rtl/bpsk_modulator.sv
// bpsk_modulator: NCO-based BPSK modulator, one signed sample per clock.
// Optional feature macro: BPSK_DIFF_ENCODE_EN (differential encoding,
// transmitted symbol = din XOR previously transmitted symbol).
// Parameters:
//   PHI_INC     phase increment per clock
//   CLK_PER_SYM clocks per symbol (4..65535)
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   din        in   data bit
//   din_valid  in   din offered
//   din_ready  out  high in the last cycle of a symbol; transfer = valid && ready
//   dout       out  signed 8-bit BPSK sample
//   sym_strobe out  pulse on the first dout sample of every symbol
//   underflow  out  pulse after a symbol boundary with no transfer
//
// state | meaning
// IDLE  | no data accepted at last boundary, dout forced to 0
// SEND  | transmitting sym (0 -> +sin, 1 -> -sin)
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter logic [ACC_W-1:0] PHI_INC     = 32'd872415232,
    parameter int               CLK_PER_SYM = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic signed [SAMPLE_W-1:0] dout,
    output logic                       sym_strobe,
    output logic                       underflow
);

    localparam int               CNT_W    = $clog2(CLK_PER_SYM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SYM - 1);

    logic [ACC_W-1:0]           acc;
    logic [CNT_W-1:0]           cnt;
    logic                       boundary;
    logic                       transfer;
    logic                       tx_bit;
    state_t                     state;
    state_t                     next_state;
    logic                       sym;
    logic                       next_sym;
    logic                       starve;
    logic signed [SAMPLE_W-1:0] rom_data;
    logic                       zero_q;
    logic                       neg_q;
    logic                       first_q;

    assign boundary  = (cnt == CNT_LAST);
    assign din_ready = boundary;
    assign transfer  = boundary && din_valid;

`ifdef BPSK_DIFF_ENCODE_EN
    logic prev;

    assign tx_bit = din ^ prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b0;
        end else if (transfer) begin
            prev <= tx_bit;
        end
    end
`else
    assign tx_bit = din;
`endif

    // The accumulator free-runs so the carrier phase never jumps on
    // symbol, idle or underflow transitions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc + PHI_INC;
            cnt <= boundary ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sym       <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= next_state;
            sym       <= next_sym;
            underflow <= starve;
        end
    end

    always_comb begin
        next_state = state;
        next_sym   = sym;
        starve     = 1'b0;
        if (boundary) begin
            if (din_valid) begin
                next_state = SEND;
                next_sym   = tx_bit;
            end else begin
                next_state = IDLE;
                starve     = 1'b1;
            end
        end
    end

    bpsk_sin_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (acc[ACC_W-1 -: ADDR_W]),
        .data    (rom_data)
    );

    // Stage 1 delays the symbol controls to line up with the ROM read;
    // stage 2 applies sign / zeroing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q     <= 1'b1;
            neg_q      <= 1'b0;
            first_q    <= 1'b0;
            dout       <= '0;
            sym_strobe <= 1'b0;
        end else begin
            zero_q     <= (state == IDLE);
            neg_q      <= sym;
            first_q    <= (cnt == '0);
            sym_strobe <= first_q;
            if (zero_q) begin
                dout <= '0;
            end else if (neg_q) begin
                dout <= -rom_data;
            end else begin
                dout <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// tb_bpsk_modulator: self-checking bench for bpsk_modulator.
// Main DUT uses default parameters; a second instance with PHI_INC = pi per
// clock and 4 clocks per symbol exercises the accumulator wrap case.
module tb_bpsk_modulator;

    localparam logic [31:0] PHI = 32'd872415232;

`ifdef BPSK_DIFF_ENCODE_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              din;
    logic              din_valid;
    logic              din_ready;
    logic signed [7:0] dout;
    logic              sym_strobe;
    logic              underflow;

    logic              din_pi;
    logic              din_valid_pi;
    logic              din_ready_pi;
    logic signed [7:0] dout_pi;
    logic              sym_strobe_pi;
    logic              underflow_pi;

    bpsk_modulator u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .sym_strobe (sym_strobe),
        .underflow  (underflow)
    );

    bpsk_modulator #(
        .PHI_INC     (32'h80000000),
        .CLK_PER_SYM (4)
    ) u_dut_pi (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din_pi),
        .din_valid  (din_valid_pi),
        .din_ready  (din_ready_pi),
        .dout       (dout_pi),
        .sym_strobe (sym_strobe_pi),
        .underflow  (underflow_pi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit valid;
        bit din;
        bit idle;
        bit sym_plain;
        bit sym_diff;
    } vec_t;

    typedef struct {
        bit idle;
        bit sym;
    } slot_t;

    vec_t        vec [17];
    slot_t       sq [$];
    slot_t       cur;
    int          n;
    int          n_assert;
    int          n_fail;
    bit          uf_pending;
    logic [31:0] ph;

    function automatic int ref_sin(input int k);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
        if (r >= 0.0) return int'($floor(r + 0.5));
        return -int'($floor(-r + 0.5));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    task automatic push_slot(input bit idle, input bit sym);
        slot_t s;
        s.idle = idle;
        s.sym  = sym;
        sq.push_back(s);
    endtask

    task automatic check_cycle();
        bit exp_strobe;
        int tab;
        int ex;
        chk("din_ready", int'(din_ready), int'(n % 16 == 15));
        chk("underflow", int'(underflow), (n >= 16 && n % 16 == 0) ? int'(uf_pending) : 0);
        exp_strobe = (n >= 2) && ((n - 2) % 16 == 0);
        chk("sym_strobe", int'(sym_strobe), int'(exp_strobe));
        if (exp_strobe) begin
            if (sq.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL scoreboard_empty at cycle %0d: got 0 entries, expected 1", n);
            end else begin
                cur = sq.pop_front();
            end
        end
        if (n >= 2) begin
            tab = ref_sin(int'(ph[31:22]));
            ex  = cur.idle ? 0 : (cur.sym ? -tab : tab);
            ph  = ph + PHI;
        end else begin
            ex = 0;
        end
        chk("dout", int'(dout), ex);
        chk("pi_din_ready", int'(din_ready_pi), int'(n % 4 == 3));
        chk("pi_sym_strobe", int'(sym_strobe_pi), int'((n >= 2) && ((n - 2) % 4 == 0)));
        chk("pi_dout", int'(dout_pi), 0);
        chk("pi_underflow", int'(underflow_pi), 0);
    endtask

    // Runs from the current negedge (cycle n) until cycle stop_n has been
    // checked, offering table entries lo..hi at successive boundaries and
    // noise on din/din_valid in between.
    task automatic run_until(input int lo, input int hi, input int stop_n);
        int e;
        e = lo;
        while (n <= stop_n) begin
            check_cycle();
            if (n == stop_n) break;
            if (n % 16 == 15) begin
                if (e <= hi) begin
                    din_valid  = vec[e].valid;
                    din        = vec[e].din;
                    push_slot(vec[e].idle, DIFF ? vec[e].sym_diff : vec[e].sym_plain);
                    uf_pending = !vec[e].valid;
                    e++;
                end else begin
                    din_valid  = 1'b0;
                    din        = 1'b0;
                    push_slot(1'b1, 1'b0);
                    uf_pending = 1'b1;
                end
            end else begin
                din_valid = 1'($urandom_range(0, 1));
                din       = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic restart();
        n          = 0;
        ph         = '0;
        uf_pending = 1'b0;
        sq.delete();
        push_slot(1'b1, 1'b0);
        cur.idle = 1'b1;
        cur.sym  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          valid din idle plain diff
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        n_assert     = 0;
        n_fail       = 0;
        n            = 0;
        reset_n      = 1'b0;
        din          = 1'b0;
        din_valid    = 1'b0;
        din_pi       = 1'b1;
        din_valid_pi = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_din_ready", int'(din_ready), 0);
        chk("reset_sym_strobe", int'(sym_strobe), 0);
        chk("reset_underflow", int'(underflow), 0);

        reset_n = 1'b1;
        restart();
        run_until(0, 13, 231);

        // Cycle 231: counter 7, sending the last table symbol.
        chk("pre_reset_dout_nonzero", int'(dout != 0), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_dout", int'(dout), 0);
        chk("async_reset_din_ready", int'(din_ready), 0);
        chk("async_reset_sym_strobe", int'(sym_strobe), 0);
        chk("async_reset_underflow", int'(underflow), 0);
        @(negedge clk);
        chk("held_reset_dout", int'(dout), 0);
        chk("held_reset_strobe", int'(sym_strobe), 0);
        @(negedge clk);
        reset_n = 1'b1;
        restart();
        run_until(14, 16, 70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bpsk_modulator.md
BPSK_MODULATOR -- requirements
Module: bpsk_modulator

Interface
REQ-001 SHALL have parameter PHI_INC, default 32'd872415232, phase increment per clock (3.25 MHz carrier at 16 MHz clk).
REQ-002 SHALL have parameter CLK_PER_SYM, default 16, clocks per symbol; legal range 4..65535.
REQ-003 SHALL have port clk  input  1  system clock, 16 MHz; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port din  input  1  data bit to transmit.
REQ-006 SHALL have port din_valid  input  1  din holds a bit offered for transmission.
REQ-007 SHALL have port din_ready  output  1  block accepts din this cycle; transfer when din_valid && din_ready.
REQ-008 SHALL have port dout  output signed 8  modulated BPSK sample, one per clock.
REQ-009 SHALL have port sym_strobe  output  1  one-cycle pulse on the first dout sample of each symbol, idle symbols included.
REQ-010 SHALL have port underflow  output  1  one-cycle pulse when a symbol boundary passes with no transfer.

Function
REQ-011 SHALL keep a 32-bit phase accumulator incremented by PHI_INC every clock, wrapping modulo 2^32, never cleared except by reset.
REQ-012 SHALL address a 1024-entry sine table with accumulator bits [31:22]; entries are round(127*sin(2*pi*k/1024)), range -127..+127.
REQ-013 SHALL keep a symbol counter 0..CLK_PER_SYM-1, wrapping to 0 after CLK_PER_SYM-1.
REQ-014 SHALL assert din_ready only while the counter equals CLK_PER_SYM-1, otherwise 0.
REQ-015 SHALL use states IDLE (dout forced 0) and SEND; a transfer at a boundary enters or stays in SEND, a boundary with no transfer enters or stays in IDLE and pulses underflow.
REQ-016 SHALL produce in SEND dout = +table sample for transmitted symbol 0 and -table sample for symbol 1; negation never overflows because the table is bounded at ±127.
REQ-017 SHALL have a fixed pipeline of 2 clocks: table read registered, sign/idle mux registered. The first dout sample of a symbol accepted at edge E appears at edge E+2, and sym_strobe is high in that same cycle.
REQ-018 SHALL keep carrier phase continuous across symbol, idle and underflow transitions; only the sign or the zeroing changes.
REQ-019 SHALL ignore din and din_valid whenever din_ready=0; a din_valid held high across non-boundary cycles causes no side effect.

Reset
REQ-020 SHALL, while reset_n=0 and immediately on its assertion (asynchronous), drive dout=0, din_ready=0, sym_strobe=0, underflow=0, and clear the accumulator, counter, pipeline and differential register, with state IDLE.
REQ-021 SHALL, after reset_n rises, assert din_ready first in cycle CLK_PER_SYM-1 (counter starts at 0 on the first edge after release).
REQ-022 SHALL, on reset asserted mid-symbol, discard the current symbol, with no partial-symbol completion after release.

Configuration
REQ-023 SHALL, with macro BPSK_DIFF_ENCODE_EN defined, transmit symbol = din XOR prev, where prev updates to the transmitted symbol on each transfer, resets to 0 and is unchanged by idle symbols.
REQ-024 SHALL, without BPSK_DIFF_ENCODE_EN, transmit symbol = din directly.

Structure
REQ-025 SHALL place the table address width (10), sample width (8), accumulator width (32) and state encoding typedef in shared package bpsk_pkg.
REQ-026 SHALL implement the sine table as one sub-module bpsk_sin_rom (registered read, 1-clock latency); all other logic stays in bpsk_modulator.

Verification
REQ-027 SHALL test: reset, then din_valid=1 with din=0 continuously -> din_ready pulses every 16 clocks, dout equals the table sequence for phase n*PHI_INC delayed 2 clocks, sym_strobe every 16 clocks.
REQ-028 SHALL test: din alternating 1,0,1,0 -> dout sign inverts at each sym_strobe with no phase jump (|dout| matches the 0-symbol reference).
REQ-029 SHALL test: din_valid low across one boundary -> underflow pulse, dout=0 for 16 samples starting 2 clocks after the boundary, SEND resumes on the next transfer.
REQ-030 SHALL test, with BPSK_DIFF_ENCODE_EN: din 1,1,0,1 -> transmitted symbols 1,0,0,1; without the macro -> 1,1,0,1.
REQ-031 SHALL test: reset_n low at counter=7 in SEND -> dout=0 in the same cycle without waiting for clk; after release, first din_ready at cycle 15.
REQ-032 SHALL test: PHI_INC=32'h80000000 -> table address alternates 0,512, and dout alternates 0,0 (sin 0, sin pi) across accumulator wrap with no X or glitch.
